elevator_sequencer: RTL

//  Car-level controller: latches floor calls, runs direction-collective (SCAN) scheduling,

---
 rtl/elevator_pkg.sv | 21 ++
 rtl/elevator_timer.sv | 30 +++
 rtl/elevator_sequencer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator car sequencer.
// The state encoding, the default timing values and the floor-index width helper live here.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_MOVING       = 2'd1,
        ST_DOOR_OPEN    = 2'd2,
        ST_DOOR_CLOSING = 2'd3
    } state_t;

    localparam int DEF_NUM_FLOORS = 4;
    localparam int DEF_FLOOR_TIME = 4;
    localparam int DEF_DOOR_TIME  = 3;

    // Width of a floor index, never narrower than one bit.
    function automatic int floor_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter that paces travel, door dwell and door closing.
// It stops at 1 and raises done there, so the cycle in which done is high is the terminal cycle.
module elevator_timer
    import elevator_pkg::*;
#(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          hold_reload,
    input  logic [CW-1:0] value,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load || hold_reload) begin
            count <= value;
        end else if (count > CW'(1)) begin
            count <= count - CW'(1);
        end
    end

    assign done = (count == CW'(1));

endmodule

// File: rtl/elevator_sequencer.sv
// Car-level controller: latches floor calls, schedules them direction-collectively (SCAN),
// paces travel between floors and sequences the door open/dwell/close cycle.
module elevator_sequencer
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = DEF_NUM_FLOORS,
    parameter int FLOOR_TIME = DEF_FLOOR_TIME,
    parameter int DOOR_TIME  = DEF_DOOR_TIME
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_FLOORS-1:0]            call_req,
    input  logic                             weight_limit_exceeded,
    output logic [floor_w(NUM_FLOORS)-1:0]   current_floor,
    output logic                             dir_up,
    output logic                             moving,
    output logic                             move_start,
    output logic                             door_open,
    output logic                             door_closing,
    output logic [NUM_FLOORS-1:0]            pending
);

    localparam int FW    = floor_w(NUM_FLOORS);
    localparam int T_MAX = (FLOOR_TIME > DOOR_TIME) ? FLOOR_TIME : DOOR_TIME;
    localparam int CW    = $clog2(T_MAX + 1);

    state_t                  state;
    logic [FW-1:0]           next_floor;
    logic                    here_call;
    logic                    ahead_cur;
    logic                    behind_cur;
    logic                    ahead_next;
    logic                    cur_hold;
    logic                    depart;
    logic                    arrive;
    logic                    arrive_open;
    logic                    arrive_cont;
    logic                    tmr_load;
    logic                    tmr_hold;
    logic [CW-1:0]           tmr_val;
    logic                    tmr_done;
    logic                    svc_en;
    logic [FW-1:0]           svc_floor;
    logic [NUM_FLOORS-1:0]   svc_mask;

    // Masked OR of pending calls strictly above (up=1) or strictly below (up=0) floor f.
    function automatic logic calls_toward(input logic [NUM_FLOORS-1:0] p,
                                          input logic [FW-1:0]         f,
                                          input logic                  up);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if ((up && (i > int'(f))) || (!up && (i < int'(f))))
                hit = hit | p[i];
        end
        return hit;
    endfunction

    always_comb begin
        next_floor = current_floor;
        if (dir_up && (current_floor != FW'(NUM_FLOORS - 1)))
            next_floor = current_floor + FW'(1);
        else if (!dir_up && (current_floor != '0))
            next_floor = current_floor - FW'(1);
    end

    always_comb begin
        here_call   = pending[current_floor];
        ahead_cur   = calls_toward(pending, current_floor, dir_up);
        behind_cur  = calls_toward(pending, current_floor, !dir_up);
        ahead_next  = calls_toward(pending, next_floor, dir_up);
        cur_hold    = weight_limit_exceeded | call_req[current_floor];
        depart      = !here_call && !weight_limit_exceeded && (ahead_cur || behind_cur);
        arrive      = (state == ST_MOVING) && tmr_done;
        arrive_open = arrive && pending[next_floor];
        arrive_cont = arrive && !pending[next_floor] && ahead_next;
    end

    // One timer serves travel, dwell and closing; only one of them is ever running.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_hold  = 1'b0;
        tmr_val   = CW'(DOOR_TIME);
        svc_en    = 1'b0;
        svc_floor = current_floor;
        case (state)
            ST_IDLE: begin
                if (here_call) begin
                    tmr_load = 1'b1;
                    svc_en   = 1'b1;
                end else if (depart) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(FLOOR_TIME);
                end
            end
            ST_MOVING: begin
                if (arrive_open) begin
                    tmr_load  = 1'b1;
                    svc_en    = 1'b1;
                    svc_floor = next_floor;
                end else if (arrive_cont) begin
                    tmr_load = 1'b1;
                    tmr_val  = CW'(FLOOR_TIME);
                end
            end
            ST_DOOR_OPEN: begin
                svc_en   = 1'b1;
                tmr_hold = cur_hold;
                tmr_load = tmr_done;
            end
            ST_DOOR_CLOSING: begin
                svc_en   = 1'b1;
                tmr_hold = cur_hold;
            end
            default: ;
        endcase
    end

    always_comb begin
        svc_mask = '0;
        if (svc_en)
            svc_mask[svc_floor] = 1'b1;
    end

    elevator_timer #(
        .CW(CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .hold_reload(tmr_hold),
        .value      (tmr_val),
        .done       (tmr_done)
    );

    // A call for the floor being serviced is absorbed instead of latched.
    always_ff @(posedge clk) begin
        if (rst)
            pending <= '0;
        else
            pending <= (pending | call_req) & ~svc_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            current_floor <= '0;
            dir_up        <= 1'b1;
            moving        <= 1'b0;
            move_start    <= 1'b0;
            door_open     <= 1'b0;
            door_closing  <= 1'b0;
        end else begin
            move_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (here_call) begin
                        state     <= ST_DOOR_OPEN;
                        door_open <= 1'b1;
                    end else if (depart) begin
                        state      <= ST_MOVING;
                        moving     <= 1'b1;
                        move_start <= 1'b1;
                        if (!ahead_cur)
                            dir_up <= !dir_up;
                    end
                end
                ST_MOVING: begin
                    if (arrive) begin
                        current_floor <= next_floor;
                        if (arrive_open) begin
                            state     <= ST_DOOR_OPEN;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                        end else if (!arrive_cont) begin
                            state  <= ST_IDLE;
                            moving <= 1'b0;
                        end
                    end
                end
                ST_DOOR_OPEN: begin
                    if (!cur_hold && tmr_done) begin
                        state        <= ST_DOOR_CLOSING;
                        door_closing <= 1'b1;
                    end
                end
                ST_DOOR_CLOSING: begin
                    if (cur_hold) begin
                        state        <= ST_DOOR_OPEN;
                        door_closing <= 1'b0;
                    end else if (tmr_done) begin
                        state        <= ST_IDLE;
                        door_open    <= 1'b0;
                        door_closing <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
